// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the HH:MM BCD stopwatch: FSM state encoding,
// BCD digit limits and the preset legality check.
package bcd_stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2
  } state_e;

  localparam logic [3:0] DIGIT_MAX          = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX       = 4'd5;
  localparam logic [3:0] HR_TENS_MAX        = 4'd2;
  localparam logic [3:0] HR_UNITS_MAX_AT_20 = 4'd3;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } hhmm_t;

  // True when t is a reachable count value, 00:00 .. 23:59.
  function automatic logic hhmm_legal(hhmm_t t);
    return (t.ms_hr  <= HR_TENS_MAX)  &&
           (t.ls_hr  <= DIGIT_MAX)    &&
           (t.ms_min <= MIN_TENS_MAX) &&
           (t.ls_min <= DIGIT_MAX)    &&
           !((t.ms_hr == HR_TENS_MAX) && (t.ls_hr > HR_UNITS_MAX_AT_20));
  endfunction

endpackage

// File: rtl/bcd_hhmm_counter.sv
// Four-digit BCD HH:MM counter with clear > load > increment priority.
// Wraps 23:59 -> 00:00; load values are assumed already checked for legality.
module bcd_hhmm_counter
  import bcd_stopwatch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  load_i,
  input  logic  inc_i,
  input  hhmm_t load_val_i,
  output hhmm_t cnt_o
);

  hhmm_t cnt_q, cnt_d, inc_val;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    inc_val = cnt_q;
    if (cnt_q.ls_min != DIGIT_MAX) begin
      inc_val.ls_min = cnt_q.ls_min + 4'd1;
    end else begin
      inc_val.ls_min = '0;
      if (cnt_q.ms_min != MIN_TENS_MAX) begin
        inc_val.ms_min = cnt_q.ms_min + 4'd1;
      end else begin
        inc_val.ms_min = '0;
        if ((cnt_q.ms_hr == HR_TENS_MAX) && (cnt_q.ls_hr == HR_UNITS_MAX_AT_20)) begin
          inc_val.ms_hr = '0;
          inc_val.ls_hr = '0;
        end else if (cnt_q.ls_hr != DIGIT_MAX) begin
          inc_val.ls_hr = cnt_q.ls_hr + 4'd1;
        end else begin
          inc_val.ls_hr = '0;
          inc_val.ms_hr = cnt_q.ms_hr + 4'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (inc_i)  cnt_d = inc_val;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so all
  // flops see pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// HH:MM BCD stopwatch: IDLE/RUN/PAUSE control FSM, run-only tick prescaler and
// lap capture register around a bcd_hhmm_counter. All outputs are flop outputs.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       lap,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_ms_hr,
  input  logic [3:0] load_ls_hr,
  input  logic [3:0] load_ms_min,
  input  logic [3:0] load_ls_min,
  output logic [2:0] FSM_state,
  output logic [3:0] cnt_ms_hr,
  output logic [3:0] cnt_ls_hr,
  output logic [3:0] cnt_ms_min,
  output logic [3:0] cnt_ls_min,
  output logic [3:0] lap_ms_hr,
  output logic [3:0] lap_ls_hr,
  output logic [3:0] lap_ms_min,
  output logic [3:0] lap_ls_min
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  hhmm_t         lap_q, lap_d;
  hhmm_t         cnt, load_val;
  logic          load_ok, cnt_clr, cnt_load, cnt_inc;

  assign load_val = {load_ms_hr, load_ls_hr, load_ms_min, load_ls_min};
  // A rejected load (in RUN or illegal preset) falls through to the lower-priority inputs.
  assign load_ok  = load && (state_q != ST_RUN) && hhmm_legal(load_val);

  always_comb begin
    state_d  = state_q;
    presc_d  = '0;
    lap_d    = lap_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      lap_d   = '0;
      cnt_clr = 1'b1;
    end else if (load_ok) begin
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else begin
            if (lap) lap_d = cnt;
            if (presc_q == PRESC_LAST) cnt_inc = 1'b1;
            else                       presc_d = presc_q + PW'(1);
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: only control and datapath flops are reset here; there are no memories,
  // so every register gets a defined value on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
    end
  end

  bcd_hhmm_counter u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .inc_i      (cnt_inc),
    .load_val_i (load_val),
    .cnt_o      (cnt)
  );

  assign FSM_state  = state_q;
  assign cnt_ms_hr  = cnt.ms_hr;
  assign cnt_ls_hr  = cnt.ls_hr;
  assign cnt_ms_min = cnt.ms_min;
  assign cnt_ls_min = cnt.ls_min;
  assign lap_ms_hr  = lap_q.ms_hr;
  assign lap_ls_hr  = lap_q.ls_hr;
  assign lap_ms_min = lap_q.ms_min;
  assign lap_ls_min = lap_q.ls_min;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: directed vector table plus random stimulus, with two
// instances (TICK_DIV=1 and 3) compared against a minute-counting reference model.
module tb_bcd_stopwatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, stop = 1'b0, lap = 1'b0, clr = 1'b0, load = 1'b0;
  logic [15:0] ld = '0;

  wire [2:0]  st1, st3;
  wire [15:0] c1, c3, l1, l3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_stopwatch #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .lap(lap), .clr(clr), .load(load),
    .load_ms_hr(ld[15:12]), .load_ls_hr(ld[11:8]), .load_ms_min(ld[7:4]), .load_ls_min(ld[3:0]),
    .FSM_state(st1),
    .cnt_ms_hr(c1[15:12]), .cnt_ls_hr(c1[11:8]), .cnt_ms_min(c1[7:4]), .cnt_ls_min(c1[3:0]),
    .lap_ms_hr(l1[15:12]), .lap_ls_hr(l1[11:8]), .lap_ms_min(l1[7:4]), .lap_ls_min(l1[3:0])
  );

  bcd_stopwatch #(.TICK_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .lap(lap), .clr(clr), .load(load),
    .load_ms_hr(ld[15:12]), .load_ls_hr(ld[11:8]), .load_ms_min(ld[7:4]), .load_ls_min(ld[3:0]),
    .FSM_state(st3),
    .cnt_ms_hr(c3[15:12]), .cnt_ls_hr(c3[11:8]), .cnt_ms_min(c3[7:4]), .cnt_ls_min(c3[3:0]),
    .lap_ms_hr(l3[15:12]), .lap_ls_hr(l3[11:8]), .lap_ms_min(l3[7:4]), .lap_ls_min(l3[3:0])
  );

  // Reference model: time held as plain minutes since 00:00.
  typedef struct {
    int st;
    int cnt;
    int lp;
    int run;
  } mdl_t;

  mdl_t m1, m3;

  typedef struct {
    logic [4:0]  ctl;  // {clr, load, stop, start, lap}
    logic [15:0] ld;
    logic [2:0]  st;
    logic [15:0] cnt;
    logic [15:0] lp;
  } vec_t;

  localparam logic [4:0] C_NONE = 5'b00000, C_LAP = 5'b00001, C_START = 5'b00010,
                         C_STOP = 5'b00100, C_LD = 5'b01000, C_CLR = 5'b10000;

  vec_t vecs[$];

  function automatic logic [15:0] to_bcd(int m);
    int h, mm;
    h  = m / 60;
    mm = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  // Minutes value of a preset, or -1 when it is not a time of day.
  function automatic int preset_min(logic [15:0] v);
    int d3, d2, d1, d0, hr, mn;
    d3 = int'(v[15:12]); d2 = int'(v[11:8]); d1 = int'(v[7:4]); d0 = int'(v[3:0]);
    hr = d3 * 10 + d2;
    mn = d1 * 10 + d0;
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9 || hr > 23 || mn > 59) return -1;
    return hr * 60 + mn;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int div, logic c, logic ldn, logic sp,
                                    logic sr, logic lpn, logic [15:0] v);
    mdl_t r;
    int   pre;
    r   = m;
    pre = preset_min(v);
    if (c) begin
      r = '{0, 0, 0, 0};
    end else if (ldn && m.st != 1 && pre >= 0) begin
      r.cnt = pre;
    end else if (m.st == 1) begin
      if (sp) begin
        r.st  = 2;
        r.run = 0;
      end else begin
        if (lpn) r.lp = m.cnt;
        r.run = m.run + 1;
        if (r.run == div) begin
          r.run = 0;
          r.cnt = (m.cnt + 1) % 1440;
        end
      end
    end else if (sr) begin
      r.st = 1;
    end
    return r;
  endfunction

  function automatic void add(logic [4:0] ctl, logic [15:0] v, logic [2:0] s,
                              logic [15:0] c, logic [15:0] l);
    vec_t e;
    e.ctl = ctl; e.ld = v; e.st = s; e.cnt = c; e.lp = l;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check($sformatf("%s state div1", tag), {13'd0, st1}, 16'(m1.st));
    check($sformatf("%s cnt div1", tag), c1, to_bcd(m1.cnt));
    check($sformatf("%s lap div1", tag), l1, to_bcd(m1.lp));
    check($sformatf("%s state div3", tag), {13'd0, st3}, 16'(m3.st));
    check($sformatf("%s cnt div3", tag), c3, to_bcd(m3.cnt));
    check($sformatf("%s lap div3", tag), l3, to_bcd(m3.lp));
  endtask

  task automatic step(input logic [4:0] ctl, input logic [15:0] v, input string tag);
    @(negedge clk);
    {clr, load, stop, start, lap} = ctl;
    ld = v;
    @(posedge clk);
    #1;
    m1 = mdl_step(m1, 1, ctl[4], ctl[3], ctl[2], ctl[1], ctl[0], v);
    m3 = mdl_step(m3, 3, ctl[4], ctl[3], ctl[2], ctl[1], ctl[0], v);
    compare_model(tag);
  endtask

  task automatic mid_cycle_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check($sformatf("%s rst state", tag), {13'd0, st1}, 16'd0);
    check($sformatf("%s rst cnt", tag), c1, 16'h0000);
    check($sformatf("%s rst lap", tag), l1, 16'h0000);
    check($sformatf("%s rst state div3", tag), {13'd0, st3}, 16'd0);
    check($sformatf("%s rst cnt div3", tag), c3, 16'h0000);
    m1 = '{0, 0, 0, 0};
    m3 = '{0, 0, 0, 0};
    {clr, load, stop, start, lap} = C_NONE;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [4:0]  rc;
    logic [15:0] rv;

    // Directed vectors, expectations for the TICK_DIV=1 instance.
    add(C_START, 16'h0, 3'd1, 16'h0000, 16'h0000);
    for (int i = 1; i <= 6; i++) add(C_NONE, 16'h0, 3'd1, to_bcd(i), 16'h0000);
    add(C_LAP, 16'h0, 3'd1, 16'h0007, 16'h0006);
    for (int i = 8; i <= 13; i++) add(C_NONE, 16'h0, 3'd1, to_bcd(i), 16'h0006);
    add(C_STOP, 16'h0, 3'd2, 16'h0013, 16'h0006);
    for (int i = 0; i < 5; i++) add(C_NONE, 16'h0, 3'd2, 16'h0013, 16'h0006);
    add(C_START, 16'h0, 3'd1, 16'h0013, 16'h0006);
    add(C_NONE, 16'h0, 3'd1, 16'h0014, 16'h0006);
    add(C_CLR, 16'h0, 3'd0, 16'h0000, 16'h0000);
    add(C_LD, 16'h1258, 3'd0, 16'h1258, 16'h0000);
    add(C_LD, 16'h2400, 3'd0, 16'h1258, 16'h0000);
    add(C_LD, 16'h1360, 3'd0, 16'h1258, 16'h0000);
    add(C_LD, 16'h0959, 3'd0, 16'h0959, 16'h0000);
    add(C_START, 16'h0, 3'd1, 16'h0959, 16'h0000);
    add(C_LAP, 16'h0, 3'd1, 16'h1000, 16'h0959);
    add(C_STOP, 16'h0, 3'd2, 16'h1000, 16'h0959);
    add(C_LD, 16'h1959, 3'd2, 16'h1959, 16'h0959);
    add(C_START, 16'h0, 3'd1, 16'h1959, 16'h0959);
    add(C_NONE, 16'h0, 3'd1, 16'h2000, 16'h0959);
    add(C_LD, 16'h0530, 3'd1, 16'h2001, 16'h0959);
    add(C_STOP, 16'h0, 3'd2, 16'h2001, 16'h0959);
    add(C_LD, 16'h2359, 3'd2, 16'h2359, 16'h0959);
    add(C_START, 16'h0, 3'd1, 16'h2359, 16'h0959);
    add(C_NONE, 16'h0, 3'd1, 16'h0000, 16'h0959);
    add(C_NONE, 16'h0, 3'd1, 16'h0001, 16'h0959);
    add(C_LAP, 16'h0, 3'd1, 16'h0002, 16'h0001);
    add(C_START | C_STOP, 16'h0, 3'd2, 16'h0002, 16'h0001);
    add(C_LAP, 16'h0, 3'd2, 16'h0002, 16'h0001);
    add(C_STOP, 16'h0, 3'd2, 16'h0002, 16'h0001);
    add(C_CLR | C_LD | C_START, 16'h1111, 3'd0, 16'h0000, 16'h0000);
    add(C_LD | C_START, 16'h0100, 3'd0, 16'h0100, 16'h0000);
    add(C_START, 16'h0, 3'd1, 16'h0100, 16'h0000);
    add(C_STOP, 16'h0, 3'd2, 16'h0100, 16'h0000);
    add(C_LD, 16'h1A00, 3'd2, 16'h0100, 16'h0000);

    m1 = '{0, 0, 0, 0};
    m3 = '{0, 0, 0, 0};

    #2 rst_n = 1'b0;
    #1;
    check("init rst state", {13'd0, st1}, 16'd0);
    check("init rst cnt", c1, 16'h0000);
    check("init rst lap", l1, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Run a little, then reset asynchronously mid-RUN.
    step(C_START, 16'h0, "pre");
    for (int i = 0; i < 4; i++) step(i == 2 ? C_LAP : C_NONE, 16'h0, "pre");
    mid_cycle_reset("midrun");

    foreach (vecs[i]) begin
      step(vecs[i].ctl, vecs[i].ld, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl state", i), {13'd0, st1}, {13'd0, vecs[i].st});
      check($sformatf("vec%0d tbl cnt", i), c1, vecs[i].cnt);
      check($sformatf("vec%0d tbl lap", i), l1, vecs[i].lp);
    end

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mid_cycle_reset("rand");
      rc[4] = ($urandom_range(63) == 0);
      rc[3] = ($urandom_range(7) == 0);
      rc[2] = ($urandom_range(9) == 0);
      rc[1] = ($urandom_range(5) == 0);
      rc[0] = ($urandom_range(7) == 0);
      if ($urandom_range(1) == 1) rv = to_bcd(int'($urandom_range(1439)));
      else                        rv = 16'($urandom);
      step(rc, rv, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter TICK_DIV, default 1: clock cycles per count tick (minimum 1).
REQ-002 clk  input  1  sole clock, rising-edge triggered.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  level sampled each clk edge; enter or resume RUN.
REQ-005 stop  input  1  level sampled each clk edge; pause counting.
REQ-006 lap  input  1  level sampled each clk edge; capture the current count into the lap registers.
REQ-007 clr  input  1  level sampled each clk edge; clear counts and laps, go to IDLE.
REQ-008 load  input  1  level sampled each clk edge; preset the count from the load_* inputs.
REQ-009 load_ms_hr, load_ls_hr, load_ms_min, load_ls_min  input  4 each  BCD preset digits (hour tens, hour units, minute tens, minute units).
REQ-010 FSM_state  output  3  state encoding: IDLE=0, RUN=1, PAUSE=2; values 3-7 unused.
REQ-011 cnt_ms_hr, cnt_ls_hr, cnt_ms_min, cnt_ls_min  output  4 each  running count HH:MM in BCD, registered.
REQ-012 lap_ms_hr, lap_ls_hr, lap_ms_min, lap_ls_min  output  4 each  last lap capture HH:MM in BCD, registered.

Function
REQ-013 Count range SHALL be 00:00 to 23:59; every digit SHALL always hold a legal BCD value.
REQ-014 Increment rules: ls_min 9->0 with carry; ms_min 5->0 with carry; ls_hr 9->0 with carry to ms_hr; 23:59 SHALL wrap to 00:00.
REQ-015 An internal prescaler SHALL count cycles only in RUN and SHALL clear outside RUN; one tick SHALL occur every TICK_DIV cycles spent in RUN.
REQ-016 With TICK_DIV=1, the count SHALL increment on every edge where the registered state is RUN and neither stop nor clr is sampled high.
REQ-017 Inputs SHALL be evaluated with priority clr > load > stop > start > lap.
REQ-018 clr in any state SHALL set the next state to IDLE and zero both cnt_* and lap_* on that edge.
REQ-019 load SHALL act only in IDLE or PAUSE; it SHALL copy load_* into cnt_* on that edge, leave state and lap_* unchanged, and be ignored in RUN.
REQ-020 load SHALL be ignored entirely if the preset is illegal: any digit >9, ms_min >5, ms_hr >2, or ms_hr=2 with ls_hr >3.
REQ-021 IDLE: start SHALL transition to RUN.
REQ-022 RUN: stop SHALL transition to PAUSE with the count frozen at its value before that edge.
REQ-023 RUN: lap SHALL copy the current registered cnt_* (pre-increment value) into lap_*; state stays RUN and counting continues.
REQ-024 PAUSE: start SHALL transition to RUN, resuming from the held count; lap SHALL be ignored outside RUN.
REQ-025 start while in RUN and stop outside RUN SHALL have no effect.
REQ-026 Held-high inputs SHALL re-act every cycle; no edge detection is performed.
REQ-027 FSM_state, cnt_* and lap_* SHALL all be flop outputs with zero combinational input-to-output paths.

Reset
REQ-028 rst_n low SHALL immediately force FSM_state=0 (IDLE), all cnt_*=0, all lap_*=0, and prescaler=0, regardless of clk.
REQ-029 Deassertion SHALL take effect at the next clk edge; reset asserted mid-RUN SHALL discard all counts.

Structure
REQ-030 Package bcd_stopwatch_pkg SHALL hold the state encodings (IDLE/RUN/PAUSE) and the digit limit constants (9, 5, 2, 3).
REQ-031 One sub-module bcd_hhmm_counter SHALL implement the 4-digit HH:MM increment/load/clear; the top level SHALL hold the FSM, prescaler and lap registers.

Verification
REQ-032 Reset: assert rst_n=0 mid-cycle -> outputs immediately state=0, cnt=00:00, lap=00:00.
REQ-033 Run and lap, TICK_DIV=1: 1-cycle start, then 12 cycles -> cnt=00:12; a 1-cycle lap when cnt=00:06 -> lap=00:06 while cnt continues to 00:07.
REQ-034 Stop and resume: stop at cnt=00:13 -> state=2, cnt holds 00:13 for 5 cycles; start -> state=1, next edge cnt=00:14.
REQ-035 Carries: load 09:59 in IDLE, start -> 10:00; load 19:59 -> 20:00; load 23:59 -> 00:00.
REQ-036 Clear and load: clr during RUN -> state=0, cnt=00:00, lap=00:00; then load 12:58 -> cnt=12:58, lap unchanged.
REQ-037 Rejected loads: load 24:00 in IDLE -> ignored, cnt unchanged; load 05:30 during RUN -> ignored, counting continues.
